sisc_fetch_unit: RTL and testbench
==================================

Name: sisc_fetch_unit

Overview:
- Parametrised, decoupled instruction-fetch front end for the next SISC core generation.
- Replaces direct PC→IM→IR wiring with a request/response memory interface, a prefetch queue and branch redirect/flush.
- Sits between pc/br logic and ctrl/ir.
- Lets the core tolerate variable-latency instruction memory and keep fetching while ctrl executes multicycle instructions.

Parameters:
- IW, 32: instruction width in bits.
- AW, 16: word-address width; the PC is word-addressed and increments by 1.
- DEPTH, 4: prefetch queue entries; power of 2, ≥2; also the cap on occupancy plus outstanding requests.
- RST_PC, 0: fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  AW  fetch word address (equals fetch_pc).
- imem_gnt  in  1  memory accepted the request this cycle (transfer = imem_req & imem_gnt).
- imem_rvalid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rdata  in  IW  response instruction word.
- br_taken  in  1  redirect request from ctrl/br, single-cycle pulse.
- br_addr  in  AW  redirect target.
- ir_ready  in  1  consumer accepts the head instruction.
- ir_valid  out  1  head instruction is valid.
- ir_instr  out  IW  head instruction.
- ir_pc  out  AW  address of the head instruction.
- ir_pc_inc  out  AW  ir_pc+1, modulo 2^AW (feeds br.pc_inc).

Behaviour:
- Reset (rst_f low, asynchronous):
  - fetch_pc=RST_PC; queue empty; outstanding=0; drop=0.
  - Outputs: ir_valid=0, ir_instr=0, ir_pc=0, ir_pc_inc=1, imem_req=0 (gated combinationally by rst_f), imem_addr=RST_PC.
- Credit rule: imem_req = rst_f & ~br_taken & (occupancy + outstanding < DEPTH).
  - A full queue, or one fully reserved by in-flight requests, holds req low.
- Request transfer (req & gnt): fetch_pc <= fetch_pc+1, wrapping at 2^AW; outstanding += 1.
- Response (rvalid):
  - If drop>0: discard, drop -= 1, outstanding -= 1.
  - Otherwise push {rdata, pc_of_request} into the queue, outstanding -= 1.
  - The PC of each request is tracked in a DEPTH-entry in-order tag FIFO or equivalent.
- Consume (ir_valid & ir_ready): pop the head. The next entry is visible the following cycle. Push and pop in the same cycle are allowed; occupancy is unchanged.
- Latency: with a 1-cycle memory and continuous gnt:
  - Request at cycle N, rvalid at N+1, ir_valid at N+2.
  - Steady-state throughput is 1 instruction/cycle.
- Redirect (br_taken=1), highest priority:
  - Queue flushed (occupancy 0, ir_valid=0 next cycle); a same-cycle ir_ready is ignored.
  - fetch_pc <= br_addr.
  - drop <= number of requests outstanding after this cycle, counting any response arriving this cycle as already retired. That response is always discarded.
  - imem_req is low in the redirect cycle, so no request to the stale address is granted.
  - The first request to br_addr issues the next cycle.
- Back-to-back redirects: each recomputes drop from current outstanding; the last target wins.
- Invariants:
  - occupancy + outstanding ≤ DEPTH; drop ≤ outstanding.
  - A response arriving with outstanding=0 is a protocol error, flagged by a simulation-only assertion, no RTL effect.
- Wrap-around: fetch_pc at 2^AW−1 increments to 0; ir_pc_inc at 2^AW−1 is 0.
- Reset mid-stream: all in-flight state is cleared asynchronously. Responses arriving after reset release, with outstanding=0, are ignored.

Decomposition:
- Package sisc_pkg holds IW/AW defaults, RST_PC, the queue-entry struct {instr, pc}, and a clog2-based count width for DEPTH+1.
- Sub-module sisc_fetch_fifo: parametrised synchronous FIFO (width IW+AW, DEPTH) with push, pop, flush, count, and registered head output.
- Credit, drop and tag logic stay in the top.

Test Plan:
- Reset then 1-cycle memory returning mem[a]=a+0x1000_0000, ir_ready=1:
  - imem_addr 0,1,2,… on consecutive cycles.
  - ir_instr=0x10000000 with ir_pc=0 two cycles after the first grant, then 1/cycle.
- ir_ready=0 with DEPTH=4:
  - Exactly 4 grants, then imem_req=0.
  - Raise ir_ready: instructions 0..3 pop in order and req resumes.
- 3-cycle memory latency, redirect br_taken with br_addr=0x0040 while 2 requests are outstanding:
  - Both stale responses discarded.
  - Next ir_valid shows ir_pc=0x0040 with mem[0x40].
- br_taken in the same cycle as rvalid and ir_ready:
  - Response dropped, no pop observed.
  - ir_valid=0 next cycle; next instruction delivered has ir_pc=br_addr.
- Redirect to 0xFFFF (AW=16):
  - ir_pc sequence 0xFFFF, 0x0000, 0x0001.
  - ir_pc_inc=0x0000 while ir_pc=0xFFFF.
- Assert rst_f low mid-stream with 2 outstanding:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Late responses after release are ignored; fetch restarts at RST_PC.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared defaults and helpers for the SISC instruction-fetch front end.
package sisc_pkg;

  localparam int unsigned SISC_IW     = 32;
  localparam int unsigned SISC_AW     = 16;
  localparam int unsigned SISC_DEPTH  = 4;
  localparam int unsigned SISC_RST_PC = 0;

  typedef struct packed {
    logic [SISC_IW-1:0] instr;
    logic [SISC_AW-1:0] pc;
  } fetch_entry_t;

  // Width able to hold every value 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sisc_fetch_fifo.sv
// Synchronous prefetch FIFO with flush and a registered head entry.
module sisc_fetch_fifo #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_nxt  = rd_q + PW'(1);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_nxt;
      if (do_push) wr_d = wr_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      // Head tracks the entry that will sit at rd_d after this cycle.
      if (do_pop && (cnt_q > CW'(1)))
        head_d = mem_q[rd_nxt];
      else if (do_push && ((cnt_q == '0) || (do_pop && (cnt_q == CW'(1)))))
        head_d = push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = head_q;

endmodule

// File: rtl/sisc_fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, in-order PC tags,
// prefetch queue and redirect with drop counting of stale responses.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int unsigned   IW     = SISC_IW,
  parameter int unsigned   AW     = SISC_AW,
  parameter int unsigned   DEPTH  = SISC_DEPTH,
  parameter logic [AW-1:0] RST_PC = AW'(SISC_RST_PC)
) (
  input  logic          clk,
  input  logic          rst_f,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          br_taken,
  input  logic [AW-1:0] br_addr,
  input  logic          ir_ready,
  output logic          ir_valid,
  output logic [IW-1:0] ir_instr,
  output logic [AW-1:0] ir_pc,
  output logic [AW-1:0] ir_pc_inc
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] tag_q [DEPTH];

  logic [CW-1:0] occ;
  logic [CW:0]   inflight;
  logic          xfer, resp, drop_now, push, pop;
  entry_t        push_entry, head;

  assign inflight = {1'b0, occ} + {1'b0, out_q};
  assign imem_req = rst_f & ~br_taken & (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign xfer     = imem_req & imem_gnt;
  assign resp     = imem_rvalid & (out_q != '0);
  assign drop_now = resp & (drop_q != '0);
  assign push     = resp & ~drop_now & ~br_taken;
  assign pop      = ir_valid & ir_ready & ~br_taken;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = tag_q[tag_rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (br_taken)  fetch_pc_d = br_addr;
    else if (xfer) fetch_pc_d = fetch_pc_q + AW'(1);
    out_d    = out_q + CW'(xfer) - CW'(resp);
    // On redirect every request still in flight after this cycle is stale.
    if (br_taken) drop_d = out_q - CW'(resp);
    else          drop_d = drop_q - CW'(drop_now);
    tag_wr_d = tag_wr_q + PW'(xfer);
    tag_rd_d = tag_rd_q + PW'(resp);
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      fetch_pc_q <= RST_PC;
      out_q      <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) tag_q[tag_wr_q] <= fetch_pc_q;
  end

  sisc_fetch_fifo #(
    .W     (IW + AW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst_f       (rst_f),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (br_taken),
    .count_o     (occ),
    .head_o      (head)
  );

  assign ir_valid  = (occ != '0);
  assign ir_instr  = head.instr;
  assign ir_pc     = head.pc;
  assign ir_pc_inc = head.pc + AW'(1);

`ifndef SYNTHESIS
  // Responses seen before the first grant since reset belong to a previous
  // reset epoch and are legitimately ignored.
  logic epoch_q;
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)    epoch_q <= 1'b0;
    else if (xfer) epoch_q <= 1'b1;
  end

  a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst_f)
    (imem_rvalid && epoch_q) |-> (out_q != '0))
    else $error("sisc_fetch_unit: response with no request outstanding");

  a_credit: assert property (@(posedge clk) disable iff (!rst_f)
    inflight <= (CW+1)'(DEPTH))
    else $error("sisc_fetch_unit: occupancy plus outstanding exceeds DEPTH");

  a_drop: assert property (@(posedge clk) disable iff (!rst_f)
    drop_q <= out_q)
    else $error("sisc_fetch_unit: drop count exceeds outstanding");
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit with an in-order variable-latency memory model.
module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        ir_ready;
  logic        ir_valid;
  logic [31:0] ir_instr;
  logic [15:0] ir_pc;
  logic [15:0] ir_pc_inc;

  sisc_fetch_unit #(.IW(32), .AW(16), .DEPTH(4), .RST_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .ir_ready    (ir_ready),
    .ir_valid    (ir_valid),
    .ir_instr    (ir_instr),
    .ir_pc       (ir_pc),
    .ir_pc_inc   (ir_pc_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned lat, cyc, gcount;
  int unsigned ncmp, nfail;

  function automatic logic [31:0] mem(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory captures grants, retires presented response, then presents next.
  task automatic step();
    #1;
    if (imem_rvalid && (mq.size() > 0)) void'(mq.pop_front());
    if (imem_req && imem_gnt) begin
      mq.push_back('{a: imem_addr, due: cyc + lat});
      gcount++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(mq[0].a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic do_reset(input int unsigned l);
    rst_f = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    br_taken = 1'b0; br_addr = '0; ir_ready = 1'b0;
    mq.delete();
    lat = l;
    gcount = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_f = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; (i < 20) && !ir_valid; i++) step();
    chk(tag, 32'(ir_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_f = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    br_taken = 1'b0; br_addr = '0; ir_ready = 1'b0;
    ncmp = 0; nfail = 0; cyc = 0; lat = 1; gcount = 0;

    // Asynchronous reset, checked before any clock edge
    #1 rst_f = 1'b0;
    #1;
    chk("rst_ir_valid",  32'(ir_valid),  32'd0);
    chk("rst_ir_instr",  ir_instr,       32'd0);
    chk("rst_ir_pc",     32'(ir_pc),     32'd0);
    chk("rst_ir_pc_inc", 32'(ir_pc_inc), 32'd1);
    chk("rst_imem_req",  32'(imem_req),  32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);

    // 1-cycle memory streaming
    do_reset(1);
    ir_ready = 1'b1; imem_gnt = 1'b1; #1;
    chk("t1_req_c0",  32'(imem_req),  32'd1);
    chk("t1_addr_c0", 32'(imem_addr), 32'd0);
    step();
    chk("t1_addr_c1",  32'(imem_addr), 32'd1);
    chk("t1_valid_c1", 32'(ir_valid),  32'd0);
    step();
    chk("t1_valid_c2", 32'(ir_valid),  32'd1);
    chk("t1_instr_c2", ir_instr,       32'h1000_0000);
    chk("t1_pc_c2",    32'(ir_pc),     32'd0);
    chk("t1_addr_c2",  32'(imem_addr), 32'd2);
    step();
    chk("t1_pc_c3",    32'(ir_pc),     32'd1);
    chk("t1_instr_c3", ir_instr,       32'h1000_0001);
    chk("t1_addr_c3",  32'(imem_addr), 32'd3);
    step();
    chk("t1_pc_c4",    32'(ir_pc),     32'd2);
    chk("t1_inc_c4",   32'(ir_pc_inc), 32'd3);

    // Back-pressure: credit caps grants at DEPTH
    do_reset(1);
    imem_gnt = 1'b1;
    repeat (7) step();
    chk("t2_grants",    gcount,          32'd4);
    chk("t2_req_full",  32'(imem_req),   32'd0);
    chk("t2_valid",     32'(ir_valid),   32'd1);
    chk("t2_pc_head",   32'(ir_pc),      32'd0);
    ir_ready = 1'b1;
    step();
    chk("t2_pc1",       32'(ir_pc),      32'd1);
    chk("t2_req_again", 32'(imem_req),   32'd1);
    chk("t2_addr4",     32'(imem_addr),  32'd4);
    step();
    chk("t2_pc2",       32'(ir_pc),      32'd2);
    step();
    chk("t2_pc3",       32'(ir_pc),      32'd3);
    step();
    chk("t2_pc4",       32'(ir_pc),      32'd4);
    chk("t2_instr4",    ir_instr,        32'h1000_0004);

    // 3-cycle memory, redirect with two requests outstanding
    do_reset(3);
    ir_ready = 1'b1; imem_gnt = 1'b1;
    step();
    step();
    imem_gnt = 1'b0; br_taken = 1'b1; br_addr = 16'h0040; #1;
    chk("t3_req_redirect", 32'(imem_req), 32'd0);
    step();
    br_taken = 1'b0; imem_gnt = 1'b1; #1;
    chk("t3_req_after",  32'(imem_req),  32'd1);
    chk("t3_addr_after", 32'(imem_addr), 32'h40);
    chk("t3_valid_after", 32'(ir_valid), 32'd0);
    wait_valid("t3_wait_valid");
    chk("t3_first_pc",    32'(ir_pc),    32'h40);
    chk("t3_first_instr", ir_instr,      32'h1000_0040);
    step();
    chk("t3_second_pc",   32'(ir_pc),    32'h41);

    // Redirect coinciding with a response and a consume
    do_reset(1);
    ir_ready = 1'b1; imem_gnt = 1'b1;
    step();
    step();
    chk("t4_pre_valid", 32'(ir_valid), 32'd1);
    chk("t4_pre_pc",    32'(ir_pc),    32'd0);
    br_taken = 1'b1; br_addr = 16'h0100; #1;
    chk("t4_req_redirect", 32'(imem_req), 32'd0);
    step();
    br_taken = 1'b0; #1;
    chk("t4_valid_flushed", 32'(ir_valid),  32'd0);
    chk("t4_addr_target",   32'(imem_addr), 32'h100);
    wait_valid("t4_wait_valid");
    chk("t4_pc",    32'(ir_pc), 32'h100);
    chk("t4_instr", ir_instr,   32'h1000_0100);

    // Redirect to the top of the address space
    do_reset(1);
    ir_ready = 1'b1; imem_gnt = 1'b1; br_taken = 1'b1; br_addr = 16'hFFFF; #1;
    chk("t5_req_redirect", 32'(imem_req), 32'd0);
    step();
    br_taken = 1'b0; #1;
    chk("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
    step();
    chk("t5_addr_wrap", 32'(imem_addr), 32'h0000);
    step();
    chk("t5_pc_ffff",    32'(ir_pc),     32'hFFFF);
    chk("t5_inc_wrap",   32'(ir_pc_inc), 32'h0000);
    chk("t5_instr_ffff", ir_instr,       32'h1000_FFFF);
    step();
    chk("t5_pc_0000",    32'(ir_pc),     32'h0000);
    chk("t5_instr_0000", ir_instr,       32'h1000_0000);
    step();
    chk("t5_pc_0001",    32'(ir_pc),     32'h0001);

    // Reset mid-stream with two outstanding requests
    do_reset(2);
    ir_ready = 1'b1; imem_gnt = 1'b1;
    repeat (4) step();
    chk("t6_pre_valid", 32'(ir_valid), 32'd1);
    chk("t6_pre_pc",    32'(ir_pc),    32'd1);
    imem_gnt = 1'b0;
    #1 rst_f = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(ir_valid),  32'd0);
    chk("t6_rst_instr", ir_instr,       32'd0);
    chk("t6_rst_pc",    32'(ir_pc),     32'd0);
    chk("t6_rst_inc",   32'(ir_pc_inc), 32'd1);
    chk("t6_rst_req",   32'(imem_req),  32'd0);
    chk("t6_rst_addr",  32'(imem_addr), 32'd0);
    step();
    rst_f = 1'b1;
    step();
    chk("t6_late_valid", 32'(ir_valid),  32'd0);
    chk("t6_restart_req",  32'(imem_req),  32'd1);
    chk("t6_restart_addr", 32'(imem_addr), 32'd0);
    imem_gnt = 1'b1;
    step();
    chk("t6_valid_c7", 32'(ir_valid), 32'd0);
    wait_valid("t6_wait_valid");
    chk("t6_pc",    32'(ir_pc), 32'd0);
    chk("t6_instr", ir_instr,   32'h1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
